// File: rtl/ps2_key_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the key decoder and its consumer.
// The status outputs (shift_held, caps_lock, overflow) travel with the event stream.
interface ps2_key_decoder_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [10:0] ev_data;
    logic        ev_valid;
    logic        ev_ready;
    logic        shift_held;
    logic        caps_lock;
    logic        overflow;

    modport master (
        output rx_byte, rx_valid, ev_ready,
        input  ev_data, ev_valid, shift_held, caps_lock, overflow
    );

    modport slave (
        input  rx_byte, rx_valid, ev_ready,
        output ev_data, ev_valid, shift_held, caps_lock, overflow
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte decoder: prefix FSM, typematic repeat detection, shift/caps tracking,
// and a first-word fall-through event FIFO.
//
// state     | meaning
// IDLE      | waiting for a prefix or a plain make code
// GOT_E0    | extended prefix seen
// GOT_F0    | break prefix seen
// GOT_E0F0  | extended break prefix seen
// PAUSE     | swallowing the Pause/Break sequence, skip_cnt bytes left
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic            CLOCK,
    input logic            rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        PAUSE
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic [8:0]    last_key;
    logic          last_valid;
    logic          shift_l, shift_r;
    logic          caps;
    logic          ovf;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          emit, e_brk, e_ext, e_norep, e_rep;
    logic [7:0]    e_code;
    logic [10:0]   ev_word;
    logic          full, pop, do_write;

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        emit      = 1'b0;
        e_brk     = 1'b0;
        e_ext     = 1'b0;
        e_norep   = 1'b0;
        e_code    = bus.rx_byte;
        if (bus.rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.rx_byte == 8'hE0) begin
                        state_nxt = GOT_E0;
                    end else if (bus.rx_byte == 8'hF0) begin
                        state_nxt = GOT_F0;
                    end else if (bus.rx_byte == 8'hE1) begin
                        state_nxt = PAUSE;
                        skip_nxt  = 3'd7;
                    end else if (!(bus.rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                                       8'hFC, 8'hFE, 8'hFF})) begin
                        emit = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (bus.rx_byte == 8'hF0) begin
                        state_nxt = GOT_E0F0;
                    end else if (bus.rx_byte != 8'hE0) begin
                        emit      = 1'b1;
                        e_ext     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                GOT_F0: begin
                    emit      = 1'b1;
                    e_brk     = 1'b1;
                    state_nxt = IDLE;
                end
                GOT_E0F0: begin
                    emit      = 1'b1;
                    e_brk     = 1'b1;
                    e_ext     = 1'b1;
                    state_nxt = IDLE;
                end
                PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_nxt  = 3'd0;
                        emit      = 1'b1;
                        e_ext     = 1'b1;
                        e_code    = 8'hE1;
                        e_norep   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign e_rep    = emit && !e_brk && !e_norep && last_valid && (last_key == {e_ext, e_code});
    assign ev_word  = {e_rep, e_brk, e_ext, e_code};
    assign full     = (count == DEPTH_C);
    assign pop      = (|count) && bus.ev_ready;
    assign do_write = emit && (!full || pop);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            skip_cnt   <= 3'd0;
            last_key   <= 9'd0;
            last_valid <= 1'b0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps       <= 1'b0;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            // Key state tracks every decoded event, whether or not the FIFO has room.
            if (emit) begin
                if (!e_brk) begin
                    last_key   <= {e_ext, e_code};
                    last_valid <= 1'b1;
                end else if (last_key == {e_ext, e_code}) begin
                    last_valid <= 1'b0;
                end
                if (!e_ext && e_code == 8'h12) shift_l <= !e_brk;
                if (!e_ext && e_code == 8'h59) shift_r <= !e_brk;
                if (!e_ext && !e_brk && !e_rep && e_code == 8'h58) caps <= !caps;
            end
            if (emit && !do_write) ovf <= 1'b1;
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !pop)      count <= count + 1'b1;
            else if (!do_write && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_write) mem[wr_ptr] <= ev_word;
    end

    assign bus.ev_valid   = |count;
    assign bus.ev_data    = (|count) ? mem[rd_ptr] : 11'd0;
    assign bus.shift_held = shift_l | shift_r;
    assign bus.caps_lock  = caps;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: byte sequences in, expected event words and status out.
module tb_ps2_key_decoder;
    logic CLOCK = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
        .CLOCK (CLOCK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left on a negedge; the strobe is sampled by the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLOCK);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pop_event(input string tag, input logic [10:0] exp);
        chk({tag, "_valid"}, bus.ev_valid, 1);
        chk({tag, "_data"}, bus.ev_data, exp);
        bus.ev_ready = 1'b1;
        @(negedge CLOCK);
        bus.ev_ready = 1'b0;
    endtask

    initial begin
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.ev_ready = 1'b0;
        repeat (2) @(negedge CLOCK);
        chk("rst_valid", bus.ev_valid, 0);
        chk("rst_data", bus.ev_data, 0);
        chk("rst_shift", bus.shift_held, 0);
        chk("rst_caps", bus.caps_lock, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge CLOCK);

        // Plain make and break with the consumer always ready.
        bus.ev_ready = 1'b1;
        send_byte(8'h1C);
        chk("mk1c_valid", bus.ev_valid, 1);
        chk("mk1c_data", bus.ev_data, 11'h01C);
        @(negedge CLOCK);
        chk("mk1c_popped", bus.ev_valid, 0);
        send_byte(8'hF0);
        chk("f0_noevent", bus.ev_valid, 0);
        send_byte(8'h1C);
        chk("br1c_valid", bus.ev_valid, 1);
        chk("br1c_data", bus.ev_data, 11'h21C);
        @(negedge CLOCK);
        bus.ev_ready = 1'b0;

        // Extended make/break and a discarded byte.
        send_byte(8'hE0); send_byte(8'h75);
        pop_event("ext_mk", 11'h175);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_event("ext_br", 11'h375);
        send_byte(8'hAA);
        chk("aa_noevent", bus.ev_valid, 0);

        // Shift tracking and typematic repeat.
        send_byte(8'h12);
        chk("shift_set", bus.shift_held, 1);
        pop_event("lshift", 11'h012);
        send_byte(8'h1C);
        pop_event("mk_a", 11'h01C);
        send_byte(8'h1C);
        pop_event("rep_a", 11'h41C);
        send_byte(8'hF0); send_byte(8'h12);
        chk("shift_clr", bus.shift_held, 0);
        pop_event("br_lshift", 11'h212);
        send_byte(8'hE0); send_byte(8'h12);
        pop_event("ext12", 11'h112);
        chk("ext12_noshift", bus.shift_held, 0);
        send_byte(8'h59);
        chk("rshift_set", bus.shift_held, 1);
        pop_event("rshift", 11'h059);
        send_byte(8'hF0); send_byte(8'h59);
        chk("rshift_clr", bus.shift_held, 0);
        pop_event("br_rshift", 11'h259);

        // Caps lock toggling.
        send_byte(8'h58);
        chk("caps_on", bus.caps_lock, 1);
        pop_event("caps_mk", 11'h058);
        send_byte(8'h58);
        chk("caps_rep_hold", bus.caps_lock, 1);
        pop_event("caps_rep", 11'h458);
        send_byte(8'hF0); send_byte(8'h58);
        chk("caps_br_hold", bus.caps_lock, 1);
        pop_event("caps_br", 11'h258);
        send_byte(8'h58);
        chk("caps_off", bus.caps_lock, 0);
        pop_event("caps_mk2", 11'h058);

        // Overflow: four fit, the fifth is dropped.
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        chk("full_no_ovf", bus.overflow, 0);
        send_byte(8'h2C);
        chk("ovf_set", bus.overflow, 1);
        chk("full_head", bus.ev_data, 11'h015);
        // Push and pop together on a full FIFO.
        bus.rx_byte  = 8'h35;
        bus.rx_valid = 1'b1;
        bus.ev_ready = 1'b1;
        @(negedge CLOCK);
        bus.rx_valid = 1'b0;
        bus.ev_ready = 1'b0;
        pop_event("fifo0", 11'h01D);
        pop_event("fifo1", 11'h024);
        pop_event("fifo2", 11'h02D);
        pop_event("fifo3", 11'h035);
        chk("fifo_empty", bus.ev_valid, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // Pause/Break sequence yields exactly one event.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
        chk("pause_swallow", bus.ev_valid, 0);
        send_byte(8'h77);
        pop_event("pause", 11'h1E1);
        chk("pause_single", bus.ev_valid, 0);

        // Reset in the middle of a prefix.
        send_byte(8'hE0);
        rst_n = 1'b0;
        @(negedge CLOCK);
        chk("rst_ovf_clr", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge CLOCK);
        send_byte(8'h1C);
        pop_event("post_rst_e0", 11'h01C);

        // Reset in the middle of a pause sequence.
        send_byte(8'hE1); send_byte(8'h14);
        rst_n = 1'b0;
        @(negedge CLOCK);
        rst_n = 1'b1;
        @(negedge CLOCK);
        send_byte(8'h1C);
        pop_event("post_rst_e1", 11'h01C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-002 CLOCK  in  1  system clock; all state updates on posedge CLOCK.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rx_byte  in  8  received PS/2 scan byte from the upstream receiver, synchronous to CLOCK.
REQ-005 rx_valid  in  1  one-cycle strobe; rx_byte is valid while high.
REQ-006 ev_data  out  11  head event {repeat[10], brk[9], ext[8], code[7:0]}.
REQ-007 ev_valid  out  1  FIFO non-empty.
REQ-008 ev_ready  in  1  consumer accept; pop on posedge when ev_valid && ev_ready.
REQ-009 shift_held  out  1  left (0x12) or right (0x59) shift currently held.
REQ-010 caps_lock  out  1  caps-lock toggle state.
REQ-011 overflow  out  1  sticky; an event was dropped on a full FIFO.

Function
REQ-012 Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE; a transition occurs only on a cycle with rx_valid=1.
REQ-013 IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; 0xE1 -> PAUSE with skip counter=7; 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF -> discarded, stay IDLE; any other byte -> emit make {ext=0}, stay IDLE.
REQ-014 GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay GOT_E0; any other byte -> emit make {ext=1}, -> IDLE.
REQ-015 GOT_F0: any byte -> emit break {ext=0, code=byte}, -> IDLE.
REQ-016 GOT_E0F0: any byte -> emit break {ext=1, code=byte}, -> IDLE.
REQ-017 PAUSE: each byte decrements the skip counter; the byte that brings it to 0 emits make {ext=1, code=0xE1, repeat=0} and -> IDLE; the swallowed bytes produce no events and no shift/caps updates.
REQ-018 Emit latency: the event is written into the FIFO on the same posedge that samples the completing rx_valid; ev_valid is high in the following cycle when the FIFO was empty (1-cycle latency).
REQ-019 repeat=1 iff the event is a make whose {ext,code} equals the stored last-make key and no break of that key has occurred since; every make updates the stored key; a break of the stored key clears its valid flag.
REQ-020 shift_held: set/clear separate left/right flags on make/break of non-extended 0x12/0x59; extended 0x12/0x59 ignored; output is their OR.
REQ-021 caps_lock toggles on a make of non-extended 0x58 with repeat=0; repeat makes and breaks do not toggle it.
REQ-022 Shift/caps/repeat state updates even if the event is dropped for overflow.
REQ-023 FIFO: first-word fall-through, ev_data = head entry whenever ev_valid=1; ev_data and ev_valid stable while ev_valid && !ev_ready.
REQ-024 Full FIFO with push and no pop: new event dropped, contents unchanged, overflow set.
REQ-025 Full FIFO with push and pop in the same cycle: both occur, no drop, occupancy unchanged.
REQ-026 Empty FIFO: ev_ready ignored; a push in that cycle proceeds normally.
REQ-027 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-028 rx_valid with a byte that neither emits nor changes state: no output change.

Reset
REQ-029 rst_n low asynchronously forces FSM=IDLE, skip counter=0, FIFO empty (ev_valid=0), ev_data=0, shift_held=0, caps_lock=0, overflow=0, stored last-make invalid.
REQ-030 Reset mid-sequence (prefix or PAUSE pending) discards the partial sequence; the first byte after release is decoded from IDLE.
REQ-031 overflow clears only on reset.

Verification
REQ-032 Bytes 0x1C; 0xF0,0x1C with ev_ready=1 -> events 0x01C then 0x21C, each ev_valid one cycle after its completing strobe.
REQ-033 Bytes 0xE0,0x75; 0xE0,0xF0,0x75 -> events 0x175 then 0x375; 0xAA at any time in IDLE -> no event.
REQ-034 Bytes 0x12, 0x1C, 0x1C, 0xF0,0x12 -> events 0x012, 0x01C, 0x41C, 0x212; shift_held 1 after the first byte, 0 after the last.
REQ-035 0x58 twice, then 0xF0,0x58, then 0x58 -> caps_lock 1, stays 1 (repeat event 0x458), 1 after break, 0 after final make.
REQ-036 ev_ready=0, FIFO_DEPTH=4, send five makes -> first four held in order, fifth dropped, overflow=1; then push with ev_ready=1 on a full FIFO -> no drop.
REQ-037 Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1; assert rst_n low after 0xE0 -> next byte 0x1C gives 0x01C.
